// File: rtl/enigma_pkg.sv
// Shared Enigma types, inverse rotor wiring tables and index helpers.
// Used by the return-path engine and its rotor stage.
package enigma_pkg;

    localparam int N_CONTACTS = 26;

    typedef logic [4:0] idx_t;
    typedef logic [N_CONTACTS-1:0] contacts_t;

    typedef enum logic [1:0] {
        ROTOR_I   = 2'd0,
        ROTOR_II  = 2'd1,
        ROTOR_III = 2'd2,
        ROTOR_ID  = 2'd3
    } rotor_sel_e;

    typedef struct packed {
        logic [4:0] cnt;
        idx_t       idx;
    } enc_t;

    // I^-1 = UWYGADFPVZBECKMTHXSLRINQOJ
    localparam idx_t ROTOR_I_INV [N_CONTACTS] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,
        5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,  5'd10,
        5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17,
        5'd8,  5'd13, 5'd16, 5'd14, 5'd9
    };

    // II^-1 = AJPCZWRLFBDKOTYUQGENHXMIVS
    localparam idx_t ROTOR_II_INV [N_CONTACTS] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17,
        5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14, 5'd19,
        5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,
        5'd23, 5'd12, 5'd8,  5'd21, 5'd18
    };

    // III^-1 = TAGBPCSDQEUFVNZHYIXJWLRKOM
    localparam idx_t ROTOR_III_INV [N_CONTACTS] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18,
        5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21, 5'd13,
        5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22,
        5'd11, 5'd17, 5'd10, 5'd14, 5'd12
    };

    // Single conditional subtract; callers keep v below 52.
    function automatic idx_t mod26(input logic [5:0] v);
        logic [5:0] r;
        r = (v >= 6'd26) ? (v - 6'd26) : v;
        return r[4:0];
    endfunction

    // Index of the highest set bit plus the number of set bits.
    function automatic enc_t onehot_enc(input contacts_t v);
        enc_t e;
        e = '0;
        for (int i = 0; i < N_CONTACTS; i++) begin
            if (v[i]) begin
                e.cnt = e.cnt + 5'd1;
                e.idx = idx_t'(i);
            end
        end
        return e;
    endfunction

    function automatic contacts_t onehot_dec(input idx_t i);
        contacts_t d;
        d = '0;
        if (i < 5'd26) begin
            d[i] = 1'b1;
        end
        return d;
    endfunction

    function automatic idx_t rotor_inv(input rotor_sel_e sel,
                                       input idx_t s);
        idx_t m;
        unique case (sel)
            ROTOR_I:   m = ROTOR_I_INV[s];
            ROTOR_II:  m = ROTOR_II_INV[s];
            ROTOR_III: m = ROTOR_III_INV[s];
            default:   m = s;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rotor_inv_stage.sv
// Combinational inverse pass through one rotor at a given position.
// Ports: idx/pos/sel in, next_idx out (all indices 0..25).
import enigma_pkg::*;

module rotor_inv_stage (
    input  logic [4:0]  idx,
    input  logic [4:0]  pos,
    input  rotor_sel_e  sel,
    output logic [4:0]  next_idx
);

    idx_t s;
    idx_t m;

    always_comb begin
        s        = mod26({1'b0, idx} + {1'b0, pos});
        m        = rotor_inv(sel, s);
        // +26 keeps the difference non-negative before reduction
        next_idx = mod26({1'b0, m} + 6'd26 - {1'b0, pos});
    end

endmodule

// File: rtl/enigma_return_path.sv
// Return path: reflector contact back through rotors L, M, R, one per clock.
// Ports: clk, resetn, in/in_valid/in_ready, pos_*/sel_*, out/out_valid/out_err/out_ready.
import enigma_pkg::*;

module enigma_return_path (
    input  logic        clk,
    input  logic        resetn,
    input  logic [25:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  pos_l,
    input  logic [4:0]  pos_m,
    input  logic [4:0]  pos_r,
    input  logic [1:0]  sel_l,
    input  logic [1:0]  sel_m,
    input  logic [1:0]  sel_r,
    output logic [25:0] out,
    output logic        out_valid,
    output logic        out_err,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROT_L = 3'd1,
        ROT_M = 3'd2,
        ROT_R = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e     state;
    idx_t       idx;
    logic       err;
    idx_t       cap_pos_l;
    idx_t       cap_pos_m;
    idx_t       cap_pos_r;
    rotor_sel_e cap_sel_l;
    rotor_sel_e cap_sel_m;
    rotor_sel_e cap_sel_r;

    idx_t       cur_pos;
    rotor_sel_e cur_sel;
    idx_t       next_idx;
    enc_t       enc;

    assign enc = onehot_enc(in);

    always_comb begin
        cur_pos = '0;
        cur_sel = ROTOR_ID;
        unique case (state)
            ROT_L: begin
                cur_pos = cap_pos_l;
                cur_sel = cap_sel_l;
            end
            ROT_M: begin
                cur_pos = cap_pos_m;
                cur_sel = cap_sel_m;
            end
            ROT_R: begin
                cur_pos = cap_pos_r;
                cur_sel = cap_sel_r;
            end
            default: ;
        endcase
    end

    rotor_inv_stage u_stage (
        .idx      (idx),
        .pos      (cur_pos),
        .sel      (cur_sel),
        .next_idx (next_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            err       <= 1'b0;
            cap_pos_l <= '0;
            cap_pos_m <= '0;
            cap_pos_r <= '0;
            cap_sel_l <= ROTOR_ID;
            cap_sel_m <= ROTOR_ID;
            cap_sel_r <= ROTOR_ID;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            out_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_pos_l <= mod26({1'b0, pos_l});
                        cap_pos_m <= mod26({1'b0, pos_m});
                        cap_pos_r <= mod26({1'b0, pos_r});
                        cap_sel_l <= rotor_sel_e'(sel_l);
                        cap_sel_m <= rotor_sel_e'(sel_m);
                        cap_sel_r <= rotor_sel_e'(sel_r);
                        in_ready  <= 1'b0;
                        if (enc.cnt == 5'd1) begin
                            idx   <= enc.idx;
                            err   <= 1'b0;
                            state <= ROT_L;
                        end else begin
                            // Malformed contact skips the rotors
                            idx       <= '0;
                            err       <= 1'b1;
                            out       <= '0;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ROT_L: begin
                    idx   <= next_idx;
                    state <= ROT_M;
                end
                ROT_M: begin
                    idx   <= next_idx;
                    state <= ROT_R;
                end
                ROT_R: begin
                    idx       <= next_idx;
                    out       <= onehot_dec(next_idx);
                    out_err   <= err;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out       <= '0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_return_path.sv
// Directed bench for enigma_return_path.
// Ports of the DUT all driven/observed here.
module tb_enigma_return_path;

    logic        clk;
    logic        resetn;
    logic [25:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  pos_l;
    logic [4:0]  pos_m;
    logic [4:0]  pos_r;
    logic [1:0]  sel_l;
    logic [1:0]  sel_m;
    logic [1:0]  sel_r;
    logic [25:0] out;
    logic        out_valid;
    logic        out_err;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    enigma_return_path dut (
        .clk       (clk),
        .resetn    (resetn),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pos_l     (pos_l),
        .pos_m     (pos_m),
        .pos_r     (pos_r),
        .sel_l     (sel_l),
        .sel_m     (sel_m),
        .sel_r     (sel_r),
        .out       (out),
        .out_valid (out_valid),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [25:0] v,
                         input logic [4:0] pl, input logic [4:0] pm,
                         input logic [4:0] pr,
                         input logic [1:0] sl, input logic [1:0] sm,
                         input logic [1:0] sr);
        in    = v;
        pos_l = pl;
        pos_m = pm;
        pos_r = pr;
        sel_l = sl;
        sel_m = sm;
        sel_r = sr;
    endtask

    // Called right after the accept edge; returns cycles until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_txn(input string tag,
                           input logic [25:0] exp_out,
                           input logic exp_err,
                           input int exp_lat);
        int lat;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_out"}, {6'd0, out}, {6'd0, exp_out});
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        release_out();
    endtask

    initial begin
        int lat;
        logic [25:0] held;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        setup(26'd0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd3);
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {6'd0, out}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        resetn = 1'b1;
        tick();

        // 0 -> 20 -> 7 -> 3
        setup(26'd1, 5'd0, 5'd0, 5'd0, 2'd0, 2'd1, 2'd2);
        run_txn("chain", 26'd1 << 3, 1'b0, 4);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // pos 1 on rotor I: s=1, I^-1[1]=22, 22-1=21
        setup(26'd1, 5'd1, 5'd0, 5'd0, 2'd0, 2'd3, 2'd3);
        run_txn("offset", 26'd1 << 21, 1'b0, 4);

        // pos 27 reduces to 1: same result as above
        setup(26'd1, 5'd27, 5'd0, 5'd0, 2'd0, 2'd3, 2'd3);
        run_txn("pos_wrap", 26'd1 << 21, 1'b0, 4);

        // pos 25 on rotor I, in 25: s=24, I^-1[24]=14, 14-25+26=15
        setup(26'd1 << 25, 5'd25, 5'd0, 5'd0, 2'd0, 2'd3, 2'd3);
        run_txn("top_bit", 26'd1 << 15, 1'b0, 4);

        for (int k = 0; k < 26; k++) begin
            setup(26'd1 << k,
                  5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  2'd3, 2'd3, 2'd3);
            run_txn($sformatf("ident%0d", k), 26'd1 << k, 1'b0, 4);
        end

        setup(26'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd1, 2'd2);
        run_txn("zero_in", 26'd0, 1'b1, 1);
        setup((26'd1 << 2) | (26'd1 << 5), 5'd0, 5'd0, 5'd0, 2'd0, 2'd1, 2'd2);
        run_txn("two_bits", 26'd0, 1'b1, 1);

        // Backpressure with in_valid held high throughout
        setup(26'd1, 5'd0, 5'd0, 5'd0, 2'd0, 2'd1, 2'd2);
        in_valid = 1'b1;
        tick();
        setup(26'd1 << 1, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd3);
        wait_out(lat);
        check("bp_lat", lat, 4);
        held = out;
        check("bp_out", {6'd0, held}, {6'd0, 26'd1 << 3});
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), {6'd0, out}, {6'd0, held});
            check($sformatf("bp_busy%0d", c),
                  {30'd0, in_ready, out_valid}, 32'd1);
        end
        release_out();
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("bp2_lat", lat, 4);
        check("bp2_out", {6'd0, out}, {6'd0, 26'd1 << 1});
        release_out();

        // Reset while in ROT_M
        setup(26'd1 << 4, 5'd3, 5'd7, 5'd9, 2'd0, 2'd1, 2'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out", {6'd0, out}, 32'd0);
        check("mid_rst_idx", {27'd0, dut.idx}, 32'd0);
        setup(26'd1, 5'd0, 5'd0, 5'd0, 2'd0, 2'd1, 2'd2);
        run_txn("post_rst", 26'd1 << 3, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/enigma_return_path.md
# enigma_return_path

Sequential return-path engine for the Enigma datapath. It accepts the 26-bit one-hot contact signal leaving the reflector and walks it back through the three rotors in inverse order: left, then middle, then right. It presents the resulting lamp contact as one-hot with a valid/ready handshake. It sits between the reflector and the lamp/plugboard-out stage and processes one rotor per clock.

## Interface
- Parameters: none. The 26-contact width and the rotor tables are fixed constants.
- `clk`  in  1  single clock; all state changes on its rising edge
- `resetn`  in  1  synchronous, active-low reset
- `in`  in  26  one-hot contact from the reflector
- `in_valid`  in  1  `in` and the rotor settings are valid
- `in_ready`  out  1  block can accept; high only in IDLE
- `pos_l`, `pos_m`, `pos_r`  in  5 each  rotor positions, 0..25; values ≥ 26 are reduced mod 26 at capture
- `sel_l`, `sel_m`, `sel_r`  in  2 each  rotor type: 0 = I, 1 = II, 2 = III, 3 = identity
- `out`  out  26  one-hot lamp contact
- `out_valid`  out  1  `out` and `out_err` are valid
- `out_err`  out  1  `in` was not exactly one-hot
- `out_ready`  in  1  consumer takes the result

## Operation
- States: IDLE, ROT_L, ROT_M, ROT_R, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`: capture the encoded index, all `pos_*` and all `sel_*` into registers.
  - If `in` is valid one-hot, go to ROT_L.
  - If `in` has zero bits or two or more bits set, set `err`, clear `idx`, and go to DONE.
- **ROT_x** (one cycle per rotor, using that rotor's captured p and table T)
  - s = (idx + p) mod 26
  - m = T_inv[s]
  - idx ← (m − p + 26) mod 26
- **Width/arithmetic**
  - `idx` is 5 bits.
  - Each mod-26 step is one conditional subtract of 26 on a 6-bit sum; no divider.
  - `sel` = 3 gives T_inv[s] = s, so `idx` passes through unchanged.
- **Transitions**: ROT_L → ROT_M → ROT_R → DONE, unconditionally.
- **DONE**
  - `out_valid` = 1.
  - `out` = one-hot decode of `idx`, or all zeros when `err` = 1.
  - Hold until `out_ready` = 1, then go to IDLE.
- Input changes after capture have no effect; `in_valid` is ignored outside IDLE.

## Timing
- **Reset**: `resetn` = 0 at an edge forces, at any state including mid-operation:
  - state = IDLE
  - `in_ready` = 1, `out_valid` = 0, `out` = 0, `out_err` = 0
  - `idx` = 0
  - In-flight work is discarded.
- **Latency** (accept cycle = cycle 0, i.e. `in_valid` & `in_ready` sampled high):
  - ROT_L in cycle 1, ROT_M in cycle 2, ROT_R in cycle 3.
  - `out_valid` = 1 from cycle 4.
  - Error path: `out_valid` = 1 from cycle 1.
- **Output hold**: `out` and `out_err` are registered and stable while `out_valid` = 1.
- **Throughput**: DONE → IDLE costs one cycle after the `out_ready` handshake.
  - Best case is one character per 5 cycles.
  - `in_ready` is never high in the same cycle as `out_valid`, so there is no accept/complete overlap.
- **Handshake**: `in_valid` may be held high across a busy period; the next capture happens on the first IDLE cycle.

## Structure
- Shared package `enigma_pkg` holds:
  - `N_CONTACTS` = 26
  - contact index type (5 bits)
  - rotor-select enum {ROTOR_I, ROTOR_II, ROTOR_III, ROTOR_ID}
  - inverse wiring tables, 26 × 5-bit each:
    - I⁻¹ = UWYGADFPVZBECKMTHXSLRINQOJ
    - II⁻¹ = AJPCZWRLFBDKOTYUQGENHXMIVS
    - III⁻¹ = TAGBPCSDQEUFVNZHYIXJWLRKOM
  - one-hot↔index encode/decode functions; the encoder also reports the bit count.
- Sub-module `rotor_inv_stage`: combinational (idx, pos, sel) → new idx, instantiated once and muxed by state.

## Test plan
- **Chain of three rotors**: all pos = 0, `sel_l`/`sel_m`/`sel_r` = 0/1/2, `in` = bit 0 → `out` = bit 3 (path 0 → 20 → 7 → 3), `out_err` = 0, `out_valid` rises in cycle 4.
- **Single offset rotor**: `sel_l` = 0, `pos_l` = 1, other rotors identity, `in` = bit 0 → `out` = bit 21.
- **Identity sweep**: all `sel` = 3, random pos, every `in` bit k → `out` = bit k.
- **Malformed input**: `in` = 0, then `in` with bits 2 and 5 set → `out` = 0, `out_err` = 1, `out_valid` in cycle 1.
- **Backpressure**: hold `out_ready` = 0 for 10 cycles in DONE → `out` stable, `in_ready` = 0, a new `in_valid` is not captured; after release, the next accept happens one cycle later.
- **Reset mid-operation**: assert `resetn` = 0 during ROT_M → next cycle IDLE, `out_valid` = 0, `out` = 0, `in_ready` = 1; the following transaction completes correctly.
